// File: rtl/ps2_pkg.sv
// Shared scan-code constants and receive-state encoding for the PS/2 arrow-key decoder.
package ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_BAT   = 8'hAA;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/ps2_arrow_decoder_if.sv
// PS/2 pin pair plus decoded direction levels and raw-byte debug outputs.
interface ps2_arrow_decoder_if;

   logic       ps2_clk;
   logic       ps2_data;
   logic       left;
   logic       right;
   logic       up;
   logic       down;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_err;

   modport slave (
      input  ps2_clk, ps2_data,
      output left, right, up, down, scan_code, scan_valid, frame_err
   );

   modport master (
      output ps2_clk, ps2_data,
      input  left, right, up, down, scan_code, scan_valid, frame_err
   );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, frame FSM and mid-frame timeout.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          clk_filt;
   logic [FW-1:0] fcnt;
   logic          fall;
   logic          dat;
   rx_state_t     state, state_nxt;
   logic [2:0]    bitcnt;
   logic [TW-1:0] tcnt;
   logic          timeout;
   logic [7:0]    shreg;
   logic          par;

   assign dat     = dat_sync[1];
   // The fall is flagged in the same cycle the filtered level is about to drop.
   assign fall    = clk_filt && !clk_sync[1] && (fcnt == FW'(FILTER_LEN - 1));
   assign timeout = (state != RX_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));
   assign rx_byte = shreg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_filt <= 1'b1;
         fcnt     <= '0;
         tcnt     <= '0;
         state    <= RX_IDLE;
         bitcnt   <= '0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         if (clk_sync[1] == clk_filt) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            fcnt     <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
         if (state == RX_IDLE || fall) tcnt <= '0;
         else                          tcnt <= tcnt + 1'b1;
         state <= state_nxt;
         if (fall && state == RX_IDLE) bitcnt <= '0;
         else if (fall && state == RX_DATA) bitcnt <= bitcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fall && state == RX_DATA)   shreg <= {dat, shreg[7:1]};
      if (fall && state == RX_PARITY) par   <= dat;
   end

   always_comb begin
      state_nxt  = state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      if (timeout) begin
         state_nxt = RX_IDLE;
      end else if (fall) begin
         case (state)
            RX_IDLE:   if (!dat) state_nxt = RX_DATA;
            RX_DATA:   if (bitcnt == 3'd7) state_nxt = RX_PARITY;
            RX_PARITY: state_nxt = RX_STOP;
            RX_STOP: begin
               state_nxt = RX_IDLE;
               if (dat && (^{shreg, par})) byte_valid = 1'b1;
               else                        frame_err  = 1'b1;
            end
            default:   state_nxt = RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ps2_arrow_decoder.sv
// Turns scan-code set 2 arrow make/break sequences into held active-low direction levels.
module ps2_arrow_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input logic                 clk,
   input logic                 reset,
   ps2_arrow_decoder_if.slave  bus
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic       ext;
   logic       brk;
   logic [3:0] dir_q;
   logic [7:0] code_q;
   logic       valid_q;
   logic       err_q;

   ps2_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (bus.ps2_clk),
      .ps2_data  (bus.ps2_data),
      .rx_byte   (rx_byte),
      .byte_valid(rx_valid),
      .frame_err (rx_err)
   );

   // dir_q bit order: left, right, up, down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_q   <= 4'b1111;
         code_q  <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ext     <= 1'b0;
         brk     <= 1'b0;
      end else begin
         valid_q <= rx_valid;
         err_q   <= rx_err;
         if (rx_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (rx_valid) begin
            code_q <= rx_byte;
            if (rx_byte == SC_EXT) begin
               ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (rx_byte == SC_BAT) begin
                  dir_q <= 4'b1111;
               end else if (ext) begin
                  case (rx_byte)
                     SC_LEFT:  dir_q[3] <= brk;
                     SC_RIGHT: dir_q[2] <= brk;
                     SC_UP:    dir_q[1] <= brk;
                     SC_DOWN:  dir_q[0] <= brk;
                     default:  ;
                  endcase
               end
            end
         end
      end
   end

   assign bus.left       = dir_q[3];
   assign bus.right      = dir_q[2];
   assign bus.up         = dir_q[1];
   assign bus.down       = dir_q[0];
   assign bus.scan_code  = code_q;
   assign bus.scan_valid = valid_q;
   assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder using a shortened PS/2 bit clock and timeout.
module tb_ps2_arrow_decoder;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 400;
   localparam int H           = 20;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   ecnt;
   logic [7:0] vq[$];
   logic [3:0] dq[$];

   ps2_arrow_decoder_if bus ();

   ps2_arrow_decoder #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (bus.scan_valid) begin
         vq.push_back(bus.scan_code);
         dq.push_back({bus.left, bus.right, bus.up, bus.down});
      end
      if (bus.frame_err) ecnt++;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.ps2_data = b;
      wait_clks(H);
      bus.ps2_clk = 1'b0;
      wait_clks(H);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(1'b1);
      wait_clks(2 * H);
   endtask

   task automatic send_key(input logic [7:0] b);
      send_byte(8'hE0, 1'b0);
      send_byte(b, 1'b0);
   endtask

   task automatic release_key(input logic [7:0] b);
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(b, 1'b0);
   endtask

   function automatic logic [3:0] dir();
      return {bus.left, bus.right, bus.up, bus.down};
   endfunction

   initial begin
      int v0;
      int e0;
      checks       = 0;
      errors       = 0;
      ecnt         = 0;
      reset        = 1'b1;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      wait_clks(3);
      @(negedge clk);
      chk("reset_dir", 32'(dir()), 32'hF);
      chk("reset_code", 32'(bus.scan_code), 32'h00);
      chk("reset_valid", 32'(bus.scan_valid), 32'h0);
      chk("reset_err", 32'(bus.frame_err), 32'h0);
      reset = 1'b0;
      wait_clks(5);

      // 1: up make then break
      v0 = vq.size();
      send_key(8'h75);
      @(negedge clk);
      chk("t1_nvalid", 32'(vq.size() - v0), 32'd2);
      chk("t1_byte0", 32'(vq[v0]), 32'hE0);
      chk("t1_byte1", 32'(vq[v0+1]), 32'h75);
      chk("t1_dir_at_valid", 32'(dq[v0+1]), 32'hD);
      chk("t1_up_make", 32'(dir()), 32'hD);
      release_key(8'h75);
      @(negedge clk);
      chk("t1_up_break", 32'(dir()), 32'hF);

      // 2: two directions held together
      send_key(8'h6B);
      send_key(8'h72);
      @(negedge clk);
      chk("t2_left_down", 32'(dir()), 32'h6);
      release_key(8'h6B);
      @(negedge clk);
      chk("t2_left_rel", 32'(dir()), 32'hE);

      // 3: parity error
      v0 = vq.size();
      e0 = ecnt;
      send_byte(8'h74, 1'b1);
      @(negedge clk);
      chk("t3_err_pulse", 32'(ecnt - e0), 32'd1);
      chk("t3_no_valid", 32'(vq.size() - v0), 32'd0);
      chk("t3_dir", 32'(dir()), 32'hE);
      send_key(8'h74);
      @(negedge clk);
      chk("t3_right_make", 32'(dir()), 32'hA);
      release_key(8'h74);

      // 4: abandoned frame recovered by timeout
      e0 = ecnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      bus.ps2_data = 1'b1;
      wait_clks(TIMEOUT_CYC + 200);
      send_key(8'h74);
      @(negedge clk);
      chk("t4_right_make", 32'(dir()), 32'hA);
      chk("t4_code", 32'(bus.scan_code), 32'h74);
      chk("t4_no_err", 32'(ecnt - e0), 32'd0);
      release_key(8'h74);
      send_byte(8'h74, 1'b0);
      @(negedge clk);
      chk("t4_keypad_ignored", 32'(dir()), 32'hE);
      chk("t4_keypad_code", 32'(bus.scan_code), 32'h74);

      // 5: glitch while idle, then reset mid-frame
      v0 = vq.size();
      e0 = ecnt;
      bus.ps2_clk = 1'b0;
      wait_clks(3);
      bus.ps2_clk = 1'b1;
      wait_clks(40);
      send_key(8'h75);
      @(negedge clk);
      chk("t5_glitch_nvalid", 32'(vq.size() - v0), 32'd2);
      chk("t5_glitch_err", 32'(ecnt - e0), 32'd0);
      chk("t5_up_make", 32'(dir()), 32'hC);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      #3;
      reset = 1'b1;
      #3;
      chk("t5_reset_dir", 32'(dir()), 32'hF);
      chk("t5_reset_code", 32'(bus.scan_code), 32'h00);
      wait_clks(5);
      reset = 1'b0;
      bus.ps2_data = 1'b1;
      wait_clks(2 * H);
      send_key(8'h75);
      @(negedge clk);
      chk("t5_after_reset", 32'(dir()), 32'hD);
      chk("t5_after_code", 32'(bus.scan_code), 32'h75);

      // 6: BAT clears held directions
      send_key(8'h72);
      @(negedge clk);
      chk("t6_down_make", 32'(dir()), 32'hC);
      send_byte(8'hAA, 1'b0);
      @(negedge clk);
      chk("t6_bat_dir", 32'(dir()), 32'hF);
      chk("t6_bat_code", 32'(bus.scan_code), 32'hAA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
